// File: rtl/dcache_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_port_arbiter_if
// Description : Bundle of the two master request ports and the cache port
//               seen by dcache_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_port_arbiter_if;
    // master 0 (core load/store unit)
    logic        m0_req;
    logic        m0_we;
    logic [3:0]  m0_mask;
    logic [7:0]  m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;
    // master 1 (debug/DMA port)
    logic        m1_req;
    logic        m1_we;
    logic [3:0]  m1_mask;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;
    // cache side
    logic        c_request;
    logic        c_we;
    logic        c_re;
    logic [3:0]  c_mask;
    logic [7:0]  c_address;
    logic [31:0] c_data_in;
    logic        c_valid;
    logic [31:0] c_data_out;

    modport slave (
        input  m0_req, m0_we, m0_mask, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_mask, m1_addr, m1_wdata,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output c_request, c_we, c_re, c_mask, c_address, c_data_in,
        input  c_valid, c_data_out
    );

    modport master (
        output m0_req, m0_we, m0_mask, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_mask, m1_addr, m1_wdata,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err,
        input  c_request, c_we, c_re, c_mask, c_address, c_data_in,
        output c_valid, c_data_out
    );
endinterface
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dcache_port_arbiter
// Description : Round-robin two-master arbiter and sequencer for the
//               single-ported data cache, with a completion watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input wire                   clk,
    input wire                   rst,
    dcache_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [3:0]        mask_q, mask_d;
    logic [7:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;

    logic              w_resp;
    logic              w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            mask_q   <= 4'h0;
            addr_q   <= 8'h00;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        we_d     = we_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // a lone requester wins outright; prio only breaks ties
                    owner_d = (bus.m0_req && bus.m1_req) ? prio_q : bus.m1_req;
                    we_d    = owner_d ? bus.m1_we    : bus.m0_we;
                    mask_d  = owner_d ? bus.m1_mask  : bus.m0_mask;
                    addr_d  = owner_d ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = owner_d ? bus.m1_wdata : bus.m0_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.c_valid) begin
                    err_d = 1'b0;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = bus.c_data_out;
                        else         rdata0_d = bus.c_data_out;
                    end
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                    if (owner_q) rdata1_d = 32'h0;
                    else         rdata0_d = 32'h0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                prio_d  = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // cache-side outputs depend only on state and latched fields
    assign w_resp = (state_q == S_RESP);
    assign w_busy = (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign bus.m0_ack    = w_resp & ~owner_q;
    assign bus.m1_ack    = w_resp &  owner_q;
    assign bus.m0_err    = w_resp & ~owner_q & err_q;
    assign bus.m1_err    = w_resp &  owner_q & err_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

    assign bus.c_request = (state_q == S_ISSUE);
    assign bus.c_we      = w_busy &  we_q;
    assign bus.c_re      = w_busy & ~we_q;
    assign bus.c_mask    = mask_q;
    assign bus.c_address = addr_q;
    assign bus.c_data_in = wdata_q;
endmodule
`default_nettype wire
